fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, code memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 run  input  1  1 = fetch instructions; 0 = stop at next safe point and accept program loads.
REQ-007 jump_valid  input  1  redirect request, sampled every cycle.
REQ-008 jump_addr  input  ADDR_W  redirect target.
REQ-009 instr_valid  output  1  instr/instr_pc hold a fetched word.
REQ-010 instr_ready  input  1  downstream accepts the word.
REQ-011 instr  output  INSTR_W  fetched instruction.
REQ-012 instr_pc  output  ADDR_W  address instr was fetched from.
REQ-013 load_valid  input  1  program-load word offered.
REQ-014 load_ready  output  1  load word accepted this cycle when load_valid=1.
REQ-015 load_addr  input  ADDR_W  load destination.
REQ-016 load_data  input  INSTR_W  load word.
REQ-017 code_en  output  1  code memory strobe; memory writes on its rising edge.
REQ-018 code_rw  output  1  0 = read, 1 = write.
REQ-019 code_addr  output  ADDR_W  code memory address.
REQ-020 code_wdata  output  INSTR_W  code memory write data.
REQ-021 code_rdata  input  INSTR_W  combinational read data, valid when code_rw=0.

Function
REQ-022 FSM states: IDLE, FETCH, HOLD, WSETUP, WSTROBE; all outputs registered except load_ready and instr_valid, which decode from state.
REQ-023 IDLE: run=1 -> FETCH; else load_ready=1, and load_valid=1 latches load_addr/load_data -> WSETUP; run=1 wins over a simultaneous load_valid (load_ready=0 whenever run=1).
REQ-024 WSETUP: code_rw=1, code_addr/code_wdata = latched values, code_en=0; one cycle -> WSTROBE.
REQ-025 WSTROBE: code_en=1 with address/data/rw unchanged; one cycle -> IDLE, code_en returns 0, code_rw returns 0; a load completes exactly 2 cycles after acceptance, and a load in progress is never abandoned because of run or jump_valid.
REQ-026 FETCH: code_rw=0, code_en=0, code_addr=pc; at cycle end, if no jump and run=1: instr<=code_rdata, instr_pc<=pc, pc<=pc+1 modulo 2^ADDR_W (255 -> 0), -> HOLD.
REQ-027 FETCH with run=0 and no jump: no capture, pc unchanged -> IDLE.
REQ-028 HOLD: instr_valid=1, instr/instr_pc stable until instr_ready=1; on accept -> FETCH if run=1, else IDLE; fetch-to-valid latency 1 cycle, back-to-back throughput 1 word per 2 cycles.
REQ-029 jump_valid in FETCH or HOLD: pc<=jump_addr, held word discarded (instr_valid=0 next cycle even if instr_ready=1 this cycle), -> FETCH if run=1 else IDLE; jump_valid in IDLE: pc<=jump_addr, state per REQ-023; ignored in WSETUP/WSTROBE.
REQ-030 code_en never toggles outside WSTROBE; code_rw=1 only in WSETUP/WSTROBE.

Reset
REQ-031 rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, code_en=0, code_rw=0, code_addr=0, code_wdata=0; takes priority over every event, including mid-write (no strobe issued).

Structure
REQ-032 Package fetch_pkg holds the state enum, ADDR_W/INSTR_W defaults and RESET_PC.
REQ-033 One sub-module fetch_pc: PC register with synchronous reset, load (jump) and increment, load over increment.

Verification
REQ-034 Reset, run=1, memory 0..3 = 16'h1000..16'h1003, instr_ready=1 -> words 1000,1001,1002 with instr_pc 0,1,2, instr_valid every second cycle.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> instr stable, pc not advanced, single accept on release.
REQ-036 Jump to 8'h40 while HOLD with instr_ready=1 -> held word dropped, next instr_pc=8'h40.
REQ-037 run=0, load_valid addr 8'h05 data 16'hABCD -> code_rw=1 for 2 cycles, one code_en pulse in cycle 2, then run fetch from 5 returns 16'hABCD.
REQ-038 pc=8'hFF fetch -> instr_pc=8'hFF, next instr_pc=8'h00.
REQ-039 rst_n=0 during WSTROBE -> code_en=0 next cycle, IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int INSTR_W_DEF  = 16;
    localparam int RESET_PC_DEF = 0;

    // Control states of the fetch/load sequencer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        HOLD    = 3'd2,
        WSETUP  = 3'd3,
        WSTROBE = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: synchronous reset, jump load, increment (load wins).
module fetch_pc #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: a jump overrides the sequential increment; increment wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC_V;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches words from a combinational code memory
// into a one-entry output register and, while stopped, writes program-load
// words into the same memory with a setup cycle followed by a strobe cycle.
//
// Handshakes: a word moves on instr_* when instr_valid=1 and instr_ready=1 in
// the same cycle; a load word moves when load_valid=1 and load_ready=1 in the
// same cycle. valid never depends on ready, and the payload stays stable while
// valid=1 and ready=0 (a jump may withdraw a held instruction word).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic               code_en,
    output logic               code_rw,
    output logic [ADDR_W-1:0]  code_addr,
    output logic [INSTR_W-1:0] code_wdata,
    input  logic [INSTR_W-1:0] code_rdata,
    output logic [2:0]         dbg_state_o
);

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                code_en_q, code_en_d;
    logic                code_rw_q, code_rw_d;
    logic [ADDR_W-1:0]   code_addr_q, code_addr_d;
    logic [INSTR_W-1:0]  code_wdata_q, code_wdata_d;
    logic                pc_load;
    logic                pc_inc;
    logic [ADDR_W-1:0]   pc;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (pc_load),
        .load_addr_i (jump_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    // Next-state and registered-output decode for the fetch/load sequencer.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        code_en_d    = code_en_q;
        code_rw_d    = code_rw_q;
        code_addr_d  = code_addr_q;
        code_wdata_d = code_wdata_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;

        case (state_q)
            IDLE: begin
                pc_load = jump_valid;
                if (run) begin
                    state_d = FETCH;
                end else if (load_valid) begin
                    code_rw_d    = 1'b1;
                    code_addr_d  = load_addr;
                    code_wdata_d = load_data;
                    state_d      = WSETUP;
                end
            end
            FETCH: begin
                if (jump_valid) begin
                    pc_load = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end else if (run) begin
                    instr_d    = code_rdata;
                    instr_pc_d = pc;
                    pc_inc     = 1'b1;
                    state_d    = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (jump_valid) begin
                    pc_load = 1'b1;
                    state_d = run ? FETCH : IDLE;
                end else if (instr_ready) begin
                    state_d = run ? FETCH : IDLE;
                end
            end
            WSETUP: begin
                code_en_d = 1'b1;
                state_d   = WSTROBE;
            end
            WSTROBE: begin
                code_en_d = 1'b0;
                code_rw_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entering FETCH never coincides with an increment, so the address
        // presented is either the redirect target or the current PC.
        if (state_d == FETCH) begin
            code_addr_d = jump_valid ? jump_addr : pc;
        end
    end

    // State and registered outputs; reset overrides everything, including a write in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            code_en_q    <= 1'b0;
            code_rw_q    <= 1'b0;
            code_addr_q  <= '0;
            code_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            code_en_q    <= code_en_d;
            code_rw_q    <= code_rw_d;
            code_addr_q  <= code_addr_d;
            code_wdata_q <= code_wdata_d;
        end
    end

    assign instr_valid = (state_q == HOLD);
    assign load_ready  = (state_q == IDLE) && !run;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign code_en     = code_en_q;
    assign code_rw     = code_rw_q;
    assign code_addr   = code_addr_q;
    assign code_wdata  = code_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run
// checked against an address-level model of the delivered instruction stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        jump_valid = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        code_en;
  logic        code_rw;
  logic [7:0]  code_addr;
  logic [15:0] code_wdata;
  logic [15:0] code_rdata;
  logic [2:0]  dbg_state;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .code_en     (code_en),
    .code_rw     (code_rw),
    .code_addr   (code_addr),
    .code_wdata  (code_wdata),
    .code_rdata  (code_rdata),
    .dbg_state_o (dbg_state)
  );

  // ---------------- code memory model ----------------
  logic [15:0] mem [256];
  int          strobes = 0;

  assign code_rdata = mem[code_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);
    forever begin
      @(posedge code_en);
      strobes++;
      mem[code_addr] = code_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_load(input logic [7:0] a, input logic [15:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0]  mpc;
    logic [15:0] prev_instr;
    logic [15:0] saved8;
    logic        held_prev;
    int          s0;
    int          delivered;

    // reset state
    rst_n = 1'b0;
    cyc();
    cyc();
    check("rst_state", dbg_state, IDLE);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_code_en", code_en, 1'b0);
    check("rst_code_rw", code_rw, 1'b0);
    check("rst_code_addr", code_addr, 8'h00);
    check("rst_code_wdata", code_wdata, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 8'h00);

    // streaming fetch: a word every second cycle
    rst_n = 1'b1;
    run = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h1000 + 16'(i));
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("stream_valid", instr_valid, (k % 2) == 0);
      if (k % 2 == 0) begin
        check("stream_pc", instr_pc, 8'(k / 2 - 1));
        check("stream_instr", instr, exp_q.pop_front());
      end
    end
    run = 1'b0;
    cyc();
    check("stop_idle", dbg_state, IDLE);
    check("stop_load_ready", load_ready, 1'b1);

    // backpressure: word held stable for 5 cycles
    run = 1'b1;
    instr_ready = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", instr_valid, 1'b1);
      check("hold_instr", instr, 16'h1003);
      check("hold_pc", instr_pc, 8'h03);
      cyc();
    end
    check("hold_valid_last", instr_valid, 1'b1);
    instr_ready = 1'b1;
    cyc();
    check("release_drop_valid", instr_valid, 1'b0);
    cyc();
    check("release_next_pc", instr_pc, 8'h04);

    // jump while holding with ready=1: held word discarded
    jump_valid = 1'b1;
    jump_addr  = 8'h40;
    cyc();
    jump_valid = 1'b0;
    check("jump_drop_valid", instr_valid, 1'b0);
    cyc();
    check("jump_valid", instr_valid, 1'b1);
    check("jump_pc", instr_pc, 8'h40);
    check("jump_instr", instr, mem[8'h40]);

    // PC wrap from 0xFF
    jump_valid = 1'b1;
    jump_addr  = 8'hFF;
    cyc();
    jump_valid = 1'b0;
    cyc();
    check("wrap_pc_ff", instr_pc, 8'hFF);
    check("wrap_instr_ff", instr, mem[8'hFF]);
    cyc();
    cyc();
    check("wrap_pc_00", instr_pc, 8'h00);
    check("wrap_instr_00", instr, 16'h1000);
    run = 1'b0;
    cyc();

    // program load 0x05 <= 0xABCD
    s0 = strobes;
    offer_load(8'h05, 16'hABCD);
    check("load_ready_idle", load_ready, 1'b1);
    cyc();
    load_valid = 1'b0;
    check("wsetup_rw", code_rw, 1'b1);
    check("wsetup_en", code_en, 1'b0);
    check("wsetup_addr", code_addr, 8'h05);
    check("wsetup_wdata", code_wdata, 16'hABCD);
    check("wsetup_load_ready", load_ready, 1'b0);
    cyc();
    check("wstrobe_rw", code_rw, 1'b1);
    check("wstrobe_en", code_en, 1'b1);
    check("wstrobe_addr", code_addr, 8'h05);
    check("wstrobe_count", strobes, s0 + 1);
    cyc();
    check("wdone_en", code_en, 1'b0);
    check("wdone_rw", code_rw, 1'b0);
    check("wdone_state", dbg_state, IDLE);
    check("wdone_mem", mem[8'h05], 16'hABCD);
    jump_valid = 1'b1;
    jump_addr  = 8'h05;
    run = 1'b1;
    cyc();
    jump_valid = 1'b0;
    cyc();
    check("loaded_instr", instr, 16'hABCD);
    check("loaded_pc", instr_pc, 8'h05);
    run = 1'b0;
    cyc();

    // run and jump during a write are not allowed to abandon it
    run = 1'b0;
    offer_load(8'h06, 16'h1234);
    cyc();
    load_valid = 1'b0;
    run = 1'b1;
    jump_valid = 1'b1;
    jump_addr  = 8'h80;
    cyc();
    check("busy_strobe_en", code_en, 1'b1);
    check("busy_strobe_state", dbg_state, WSTROBE);
    jump_valid = 1'b0;
    cyc();
    check("busy_idle", dbg_state, IDLE);
    check("busy_idle_en", code_en, 1'b0);
    cyc();
    cyc();
    check("busy_next_pc", instr_pc, 8'h06);
    check("busy_next_instr", instr, 16'h1234);
    run = 1'b0;
    cyc();

    // reset during WSTROBE
    offer_load(8'h07, 16'h5555);
    cyc();
    load_valid = 1'b0;
    cyc();
    check("pre_rst_en", code_en, 1'b1);
    rst_n = 1'b0;
    cyc();
    check("rst_wstrobe_en", code_en, 1'b0);
    check("rst_wstrobe_rw", code_rw, 1'b0);
    check("rst_wstrobe_state", dbg_state, IDLE);
    rst_n = 1'b1;

    // reset during WSETUP: no strobe may follow
    s0 = strobes;
    saved8 = mem[8'h08];
    offer_load(8'h08, 16'h7777);
    cyc();
    load_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_wsetup_strobes", strobes, s0);
    check("rst_wsetup_mem", mem[8'h08], saved8);
    check("rst_wsetup_en", code_en, 1'b0);

    // fetch resumes from RESET_PC
    run = 1'b1;
    instr_ready = 1'b0;
    cyc();
    cyc();
    check("rst_pc_fetch", instr_pc, 8'h00);
    check("rst_pc_instr", instr, 16'h1000);

    // randomized run: delivered words follow the address stream
    mpc = 8'h00;
    delivered = 0;
    for (int i = 0; i < 800; i++) begin
      run         = ($urandom_range(0, 9) != 0);
      instr_ready = 1'($urandom_range(0, 1));
      jump_valid  = ($urandom_range(0, 15) == 0);
      jump_addr   = 8'($urandom_range(0, 255));
      if (jump_valid) begin
        mpc = jump_addr;
      end else if (instr_valid && instr_ready) begin
        check("rnd_pc", instr_pc, mpc);
        check("rnd_instr", instr, mem[mpc]);
        mpc = mpc + 8'd1;
        delivered++;
      end
      held_prev  = instr_valid && !instr_ready && !jump_valid;
      prev_instr = instr;
      cyc();
      if (held_prev) begin
        check("rnd_hold_valid", instr_valid, 1'b1);
        check("rnd_hold_instr", instr, prev_instr);
      end
      check("rnd_no_strobe", {code_en, code_rw}, 2'b00);
    end
    check("rnd_delivered_enough", delivered > 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
